// File: rtl/collide_pkg.sv
// Shared constants, tile codes and scan FSM encoding for the collision scanner.
// Optional feature macro: COLLIDE_HAZARD_EN (2-bit tile codes plus hit_hazard output).
package collide_pkg;

   localparam int unsigned TILE_SHIFT = 5;
   localparam int unsigned MAP_COLS   = 25;
   localparam int unsigned MAP_ROWS   = 19;
   localparam int unsigned SCREEN_W   = MAP_COLS << TILE_SHIFT;
   localparam int unsigned SCREEN_H   = MAP_ROWS << TILE_SHIFT;

   localparam int unsigned POS_W      = 10;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned DIR_W      = 2;

   localparam int unsigned DIR_UP     = 3;
   localparam int unsigned DIR_DOWN   = 2;
   localparam int unsigned DIR_LEFT   = 1;
   localparam int unsigned DIR_RIGHT  = 0;

   localparam logic [1:0] TILE_EMPTY  = 2'b00;
   localparam logic [1:0] TILE_SOLID  = 2'b01;
   localparam logic [1:0] TILE_HAZARD = 2'b10;

   typedef enum logic [1:0] {
      ST_LATCH = 2'd0,
      ST_PROBE = 2'd1,
      ST_DRAIN = 2'd2
   } scan_state_e;

   // Probes come in pairs: up, up, down, down, left, left, right, right.
   function automatic logic [DIR_W-1:0] probe_dir(input logic [IDX_W-1:0] idx);
      logic [DIR_W-1:0] d;
      case (idx[2:1])
         2'd0:    d = DIR_W'(DIR_UP);
         2'd1:    d = DIR_W'(DIR_DOWN);
         2'd2:    d = DIR_W'(DIR_LEFT);
         default: d = DIR_W'(DIR_RIGHT);
      endcase
      return d;
   endfunction

endpackage

// File: rtl/collide_probe_addr.sv
// Combinational probe generator: probe index + position snapshot -> tile address and
// out-of-range flag. Out-of-range probes address tile 0.
module collide_probe_addr
   import collide_pkg::*;
#(
   parameter int unsigned PLAYER_W = 24,
   parameter int unsigned PLAYER_H = 20,
   parameter int unsigned ADDR_W   = 9
)(
   input  logic [IDX_W-1:0]  idx,
   input  logic [POS_W-1:0]  px,
   input  logic [POS_W-1:0]  py,
   output logic              oob,
   output logic [ADDR_W-1:0] addr
);

   localparam logic [POS_W-1:0] ONE   = POS_W'(1);
   localparam logic [POS_W-1:0] W_OFF = POS_W'(PLAYER_W);
   localparam logic [POS_W-1:0] H_OFF = POS_W'(PLAYER_H);
   localparam logic [POS_W-1:0] W_M1  = POS_W'(PLAYER_W - 1);
   localparam logic [POS_W-1:0] H_M1  = POS_W'(PLAYER_H - 1);

   logic [POS_W-1:0] x;
   logic [POS_W-1:0] y;
   logic [POS_W-1:0] col;
   logic [POS_W-1:0] row;

   // Probe point just outside the player box; wraps modulo 1024 on underflow.
   always_comb begin
      x = px;
      y = py;
      case (idx)
         3'd0:    begin x = px;         y = py - ONE;  end
         3'd1:    begin x = px + W_M1;  y = py - ONE;  end
         3'd2:    begin x = px;         y = py + H_OFF; end
         3'd3:    begin x = px + W_M1;  y = py + H_OFF; end
         3'd4:    begin x = px - ONE;   y = py;         end
         3'd5:    begin x = px - ONE;   y = py + H_M1;  end
         3'd6:    begin x = px + W_OFF; y = py;         end
         default: begin x = px + W_OFF; y = py + H_M1;  end
      endcase
   end

   assign col  = x >> TILE_SHIFT;
   assign row  = y >> TILE_SHIFT;
   assign oob  = (x >= POS_W'(SCREEN_W)) || (y >= POS_W'(SCREEN_H));
   assign addr = oob ? '0 : (ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col));

endmodule

// File: rtl/collide_scan.sv
// Collision scanner: probes the tile ROM at 8 points around the player box every
// 10 cycles and publishes {up,down,left,right} blocked flags atomically.
// Optional feature macro: COLLIDE_HAZARD_EN (2-bit map_data, hit_hazard output).
module collide_scan
   import collide_pkg::*;
#(
   parameter int unsigned PLAYER_W = 24,
   parameter int unsigned PLAYER_H = 20,
   parameter int unsigned ADDR_W   = 9
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   output logic [ADDR_W-1:0] map_addr,
`ifdef COLLIDE_HAZARD_EN
   input  logic [1:0]        map_data,
   output logic              hit_hazard,
`else
   input  logic              map_data,
`endif
   output logic [3:0]        is_collide,
   output logic              scan_done
);

   scan_state_e       state, state_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [POS_W-1:0]  px, px_n;
   logic [POS_W-1:0]  py, py_n;
   logic              p_valid, p_valid_n;
   logic              p_oob, p_oob_n;
   logic [DIR_W-1:0]  p_dir, p_dir_n;
   logic [3:0]        acc, acc_n;
   logic [3:0]        acc_upd;
   logic [3:0]        is_collide_n;
   logic              scan_done_n;
   logic              solid;
   logic              probe_oob;
   logic [ADDR_W-1:0] probe_addr;
`ifdef COLLIDE_HAZARD_EN
   logic              acc_haz, acc_haz_n;
   logic              haz_upd;
   logic              hit_hazard_n;
`endif

   collide_probe_addr #(
      .PLAYER_W (PLAYER_W),
      .PLAYER_H (PLAYER_H),
      .ADDR_W   (ADDR_W)
   ) u_probe (
      .idx  (idx),
      .px   (px),
      .py   (py),
      .oob  (probe_oob),
      .addr (probe_addr)
   );

   // Address only drives the ROM while probing; idle cycles read tile 0.
   assign map_addr = (state == ST_PROBE) ? probe_addr : '0;

`ifdef COLLIDE_HAZARD_EN
   assign solid   = (map_data == TILE_SOLID);
   assign haz_upd = acc_haz | (p_valid & ~p_oob & (map_data == TILE_HAZARD));
`else
   assign solid   = map_data;
`endif

   // Fold the ROM word for last cycle's probe into the accumulator.
   always_comb begin
      acc_upd = acc;
      if (p_valid && (p_oob || solid)) begin
         acc_upd[p_dir] = 1'b1;
      end
   end

   // Scan sequencer and next-state values for all registered state.
   always_comb begin
      state_n      = state;
      idx_n        = idx;
      px_n         = px;
      py_n         = py;
      p_valid_n    = 1'b0;
      p_oob_n      = 1'b0;
      p_dir_n      = p_dir;
      acc_n        = acc_upd;
      is_collide_n = is_collide;
      scan_done_n  = 1'b0;
`ifdef COLLIDE_HAZARD_EN
      acc_haz_n    = haz_upd;
      hit_hazard_n = hit_hazard;
`endif
      case (state)
         ST_LATCH: begin
            px_n    = pos_x;
            py_n    = pos_y;
            idx_n   = '0;
            state_n = ST_PROBE;
         end
         ST_PROBE: begin
            p_valid_n = 1'b1;
            p_oob_n   = probe_oob;
            p_dir_n   = probe_dir(idx);
            idx_n     = idx + IDX_W'(1);
            if (idx == IDX_W'(7)) begin
               state_n = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            is_collide_n = acc_upd;
            scan_done_n  = 1'b1;
            acc_n        = '0;
`ifdef COLLIDE_HAZARD_EN
            hit_hazard_n = haz_upd;
            acc_haz_n    = 1'b0;
`endif
            state_n      = ST_LATCH;
         end
         default: begin
            state_n = ST_LATCH;
         end
      endcase
   end

   // State, snapshot, probe pipeline and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LATCH;
         idx        <= '0;
         px         <= '0;
         py         <= '0;
         p_valid    <= 1'b0;
         p_oob      <= 1'b0;
         p_dir      <= '0;
         acc        <= '0;
         is_collide <= '0;
         scan_done  <= 1'b0;
`ifdef COLLIDE_HAZARD_EN
         acc_haz    <= 1'b0;
         hit_hazard <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         px         <= px_n;
         py         <= py_n;
         p_valid    <= p_valid_n;
         p_oob      <= p_oob_n;
         p_dir      <= p_dir_n;
         acc        <= acc_n;
         is_collide <= is_collide_n;
         scan_done  <= scan_done_n;
`ifdef COLLIDE_HAZARD_EN
         acc_haz    <= acc_haz_n;
         hit_hazard <= hit_hazard_n;
`endif
      end
   end

endmodule

// File: tb/tb_collide_scan.sv
// Bench for collide_scan: tile ROM model, directed cases and randomized maps/positions
// checked against a geometric reference. Honours COLLIDE_HAZARD_EN if defined.
module tb_collide_scan;

   localparam int PW     = 24;
   localparam int PH     = 20;
   localparam int NTILES = 25 * 19;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] pos_x = '0;
   logic [9:0] pos_y = '0;
   logic [8:0] map_addr;
`ifdef COLLIDE_HAZARD_EN
   logic [1:0] map_data = '0;
   logic       hit_hazard;
`else
   logic       map_data = 1'b0;
`endif
   logic [3:0] is_collide;
   logic       scan_done;

   int tile_map[NTILES];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   collide_scan dut (
      .clk        (clk),
      .rst        (rst),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .map_addr   (map_addr),
      .map_data   (map_data),
`ifdef COLLIDE_HAZARD_EN
      .hit_hazard (hit_hazard),
`endif
      .is_collide (is_collide),
      .scan_done  (scan_done)
   );

   // Synchronous ROM: one cycle of read latency.
   always @(posedge clk) begin
      int a;
      a = int'(map_addr);
`ifdef COLLIDE_HAZARD_EN
      map_data <= (a < NTILES) ? 2'(tile_map[a]) : 2'b00;
`else
      map_data <= (a < NTILES) ? (tile_map[a] == 1) : 1'b0;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic clear_map();
      for (int i = 0; i < NTILES; i++) tile_map[i] = 0;
   endtask

   task automatic set_tile(input int col, input int row, input int v);
      tile_map[row * 25 + col] = v;
   endtask

   // Tile code at pixel (x,y) with 10-bit wrap; -1 means off screen.
   function automatic int tile_at(input int x, input int y);
      int xm, ym;
      xm = ((x % 1024) + 1024) % 1024;
      ym = ((y % 1024) + 1024) % 1024;
      if (xm >= 800 || ym >= 608) return -1;
      return tile_map[(ym / 32) * 25 + xm / 32];
   endfunction

   function automatic bit blk(input int x, input int y);
      int t;
      t = tile_at(x, y);
      return (t == -1) || (t == 1);
   endfunction

   function automatic bit haz(input int x, input int y);
      return tile_at(x, y) == 2;
   endfunction

   function automatic logic [3:0] ref_collide(input int px, input int py);
      logic up, dn, lf, rt;
      up = blk(px, py - 1)  | blk(px + PW - 1, py - 1);
      dn = blk(px, py + PH) | blk(px + PW - 1, py + PH);
      lf = blk(px - 1, py)  | blk(px - 1, py + PH - 1);
      rt = blk(px + PW, py) | blk(px + PW, py + PH - 1);
      return {up, dn, lf, rt};
   endfunction

   function automatic bit ref_hazard(input int px, input int py);
      return haz(px, py - 1)  | haz(px + PW - 1, py - 1)
           | haz(px, py + PH) | haz(px + PW - 1, py + PH)
           | haz(px - 1, py)  | haz(px - 1, py + PH - 1)
           | haz(px + PW, py) | haz(px + PW, py + PH - 1);
   endfunction

   // Wait (bounded) for the next scan_done pulse; n = negedges consumed.
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 40);
   endtask

   // Called in the cycle where scan_done is visible: the next scan snapshots (x,y).
   task automatic run_scan(input string tag, input int x, input int y);
      int n;
      pos_x = 10'(x);
      pos_y = 10'(y);
      wait_done(n);
      chk({tag, "_period"}, n, 10);
      chk(tag, is_collide, ref_collide(x, y));
`ifdef COLLIDE_HAZARD_EN
      chk({tag, "_haz"}, hit_hazard, ref_hazard(x, y));
`endif
   endtask

   initial begin
      int n;

      // 1: reset values, first commit latency, floor below the player.
      clear_map();
      for (int c = 0; c < 25; c++) set_tile(c, 18, 1);
      pos_x = 10'd200;
      pos_y = 10'd556;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_collide", is_collide, 0);
      chk("rst_done", scan_done, 0);
      chk("rst_addr", map_addr, 0);
`ifdef COLLIDE_HAZARD_EN
      chk("rst_haz", hit_hazard, 0);
`endif
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) chk("t1_addr_idx0", map_addr, (555 / 32) * 25 + 200 / 32);
      end while (!scan_done && n < 40);
      chk("t1_latency", n, 10);
      chk("t1_collide", is_collide, ref_collide(200, 556));
      chk("t1_const", is_collide, 4'b0100);

      // 2: screen-edge probes are blocked even on an empty map.
      clear_map();
      run_scan("t2_x0", 0, 100);
      chk("t2_left", is_collide[1], 1);
      run_scan("t2_x776", 776, 100);
      chk("t2_right", is_collide[0], 1);

      // 3: right probe crosses into a solid tile by exactly one pixel.
      clear_map();
      set_tile(8, 10, 1);
      run_scan("t3_232", 232, 320);
      chk("t3_right_on", is_collide[0], 1);
      run_scan("t3_231", 231, 320);
      chk("t3_right_off", is_collide[0], 0);

      // 4: up probe boundary.
      clear_map();
      set_tile(6, 16, 1);
      run_scan("t4_544", 200, 544);
      chk("t4_up_on", is_collide[3], 1);
      run_scan("t4_545", 200, 545);
      chk("t4_up_off", is_collide[3], 0);

      // 5: position change mid-scan does not disturb the current result.
      clear_map();
      for (int c = 0; c < 25; c++) set_tile(c, 18, 1);
      pos_x = 10'd200;
      pos_y = 10'd556;
      repeat (4) @(negedge clk);
      pos_y = 10'd500;
      wait_done(n);
      chk("t5_rest", n, 6);
      chk("t5_old", is_collide, ref_collide(200, 556));
      chk("t5_down_old", is_collide[2], 1);
      run_scan("t5_new", 200, 500);
      chk("t5_down_new", is_collide[2], 0);

      // 6: reset during PROBE idx4 aborts the scan.
      run_scan("t6_pre", 200, 556);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_collide", is_collide, 0);
      chk("t6_rst_done", scan_done, 0);
      chk("t6_rst_addr", map_addr, 0);
      rst = 1'b0;
      wait_done(n);
      chk("t6_latency", n, 10);
      chk("t6_collide", is_collide, ref_collide(200, 556));

`ifdef COLLIDE_HAZARD_EN
      // 7: hazard tile is reported but does not block.
      set_tile(6, 18, 2);
      run_scan("t7", 200, 556);
      chk("t7_hit", hit_hazard, 1);
      chk("t7_down", is_collide[2], 0);
`endif

      // Randomized maps and positions.
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < NTILES; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
`ifdef COLLIDE_HAZARD_EN
            tile_map[i] = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
`else
            tile_map[i] = (r < 2) ? 1 : 0;
`endif
         end
         run_scan($sformatf("rnd%0d", it), int'($urandom_range(0, 1023)),
                  int'($urandom_range(0, 1023)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
